// File: rtl/score4_game_engine.sv
// -----------------------------------------------------------------------------
// score4_game_engine
//
// Connect-four ("Score-4") game state engine. Owns the board, the cursor
// column and whose turn it is. Accepts single-cycle button pulses, drops the
// current player's disc with gravity, checks the landed disc for a line of
// four in each of the four directions (one direction per cycle), and
// detects a draw when the board fills up.
//
// Build option:
//   SCORE4_FALL_ANIM_EN  when defined, the disc visibly falls from row 0,
//                        advancing one row every FALL_TICKS cycles. When
//                        undefined, the disc lands in a single FALL cycle
//                        and FALL_TICKS is only range-checked.
//
// Parameters:
//   COLS        board columns (>= 4)
//   ROWS        board rows (>= 4); row ROWS-1 is the bottom row
//   FALL_TICKS  cycles per row step of the falling disc (animation only)
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-low
//   left       pulse: move cursor one column left (wraps)
//   right      pulse: move cursor one column right (wraps)
//   drop       pulse: drop current player's disc in the cursor column
//   new_game   pulse: clear the board and restart, from any state
//   panel      per-cell state [col][row]: 00 empty, 01 green, 10 red
//   play       one-hot cursor column
//   turn       1 = green to move, 0 = red to move
//   busy       high while a drop is in progress (FALL / CHECK)
//   game_over  high once the game has ended
//   winner     01 green, 10 red, 00 draw / none
//   illegal    one-cycle pulse: drop rejected because the column is full
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module score4_game_engine #(
    parameter int COLS       = 7,
    parameter int ROWS       = 6,
    parameter int FALL_TICKS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          left,
    input  logic                          right,
    input  logic                          drop,
    input  logic                          new_game,
    output logic [COLS-1:0][ROWS-1:0][1:0] panel,
    output logic [COLS-1:0]               play,
    output logic                          turn,
    output logic                          busy,
    output logic                          game_over,
    output logic [1:0]                    winner,
    output logic                          illegal
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int MW = $clog2(COLS * ROWS + 1);

    localparam logic [CW-1:0] CUR_HOME  = CW'(COLS / 2);
    localparam logic [CW-1:0] CUR_LAST  = CW'(COLS - 1);
    localparam logic [MW-1:0] LAST_MOVE = MW'(COLS * ROWS - 1);

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] GREEN = 2'b01;
    localparam logic [1:0] RED   = 2'b10;

    // Elaboration-time guard on the board geometry and animation rate.
    if (COLS < 4 || ROWS < 4 || FALL_TICKS < 1) begin : g_param_check
        $error("score4_game_engine: need COLS >= 4, ROWS >= 4, FALL_TICKS >= 1");
    end

    typedef enum logic [1:0] {IDLE, FALL, CHECK, OVER} state_t;

    // Order in which CHECK walks the four line directions.
    typedef enum logic [1:0] {DIR_H, DIR_V, DIR_DR, DIR_UR} dir_t;

    typedef logic [COLS-1:0][ROWS-1:0][1:0] board_t;

    state_t          state, state_nxt;
    board_t          board;
    logic [CW-1:0]   cursor;
    logic            turn_q;
    logic [MW-1:0]   moves;
    logic [CW-1:0]   col_q;
    logic [RW-1:0]   row_q;
    dir_t            dir_q;
    logic [1:0]      winner_q;
    logic            illegal_q;

    logic            restart;
    logic [1:0]      disc;
    logic            cur_full;
    logic            fall_done;
    logic [RW-1:0]   land_row;
    int              dc, dr;
    int              line_len;
    logic            win_hit;

    assign restart  = !rst || new_game;
    assign disc     = turn_q ? GREEN : RED;
    assign cur_full = board[cursor][0] != EMPTY;

    // Number of cells of colour `colour` contiguous with (c,r) in the
    // direction (sc,sr), not counting (c,r) itself. Stops at the board edge;
    // three steps are enough to decide a line of four.
    function automatic int run_len(input board_t b, input int c, input int r,
                                   input int sc, input int sr,
                                   input logic [1:0] colour);
        int  n;
        int  cc;
        int  rr;
        bit  go;
        n  = 0;
        go = 1'b1;
        for (int k = 1; k < 4; k++) begin
            cc = c + k * sc;
            rr = r + k * sr;
            if (go && cc >= 0 && cc < COLS && rr >= 0 && rr < ROWS) begin
                if (b[CW'(cc)][RW'(rr)] == colour) n++;
                else go = 1'b0;
            end else begin
                go = 1'b0;
            end
        end
        return n;
    endfunction

    // Line length through the landed disc for the direction under test.
    // Rows grow downwards, so "up-right" is (+1,-1).
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first; a path that leaves one unassigned would infer a latch.
        dc = 1;
        dr = 0;
        case (dir_q)
            DIR_H:   begin dc = 1; dr =  0; end
            DIR_V:   begin dc = 0; dr =  1; end
            DIR_DR:  begin dc = 1; dr =  1; end
            DIR_UR:  begin dc = 1; dr = -1; end
            default: begin dc = 1; dr =  0; end
        endcase
        line_len = 1
                 + run_len(board, int'(col_q), int'(row_q),  dc,  dr, disc)
                 + run_len(board, int'(col_q), int'(row_q), -dc, -dr, disc);
    end

    assign win_hit = line_len >= 4;

`ifdef SCORE4_FALL_ANIM_EN
    localparam int              TW        = (FALL_TICKS > 1) ? $clog2(FALL_TICKS) : 1;
    localparam logic [TW-1:0]   TICK_LAST = TW'(FALL_TICKS - 1);

    logic [TW-1:0] tick;
    logic          can_step;

    // The disc may move down if the next row exists and is still empty.
    always_comb begin
        can_step = 1'b0;
        if (int'(row_q) + 1 < ROWS)
            can_step = board[col_q][row_q + RW'(1)] == EMPTY;
    end

    assign fall_done = (tick == TICK_LAST) && !can_step;
    assign land_row  = row_q;
`else
    // Lowest empty row of the latched column: empties are contiguous from
    // the top, so the last empty found scanning downwards is the landing row.
    always_comb begin
        land_row = '0;
        for (int r = 0; r < ROWS; r++)
            if (board[col_q][RW'(r)] == EMPTY) land_row = RW'(r);
    end

    assign fall_done = 1'b1;
`endif

    // ---------------------------------------------------------------- FSM ---
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples pre-edge values regardless of statement order.
        if (restart) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (drop && !cur_full) state_nxt = FALL;
            FALL:  if (fall_done)         state_nxt = CHECK;
            CHECK: begin
                if (win_hit)
                    state_nxt = OVER;
                else if (dir_q == DIR_UR)
                    state_nxt = (moves == LAST_MOVE) ? OVER : IDLE;
            end
            OVER:    state_nxt = OVER;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        panel = board;
`ifdef SCORE4_FALL_ANIM_EN
        // Overlay the falling disc; it is only committed to the board on landing.
        if (state == FALL) panel[col_q][row_q] = disc;
`endif
        play          = '0;
        play[cursor]  = 1'b1;
        turn          = turn_q;
        busy          = (state == FALL) || (state == CHECK);
        game_over     = state == OVER;
        winner        = winner_q;
        illegal       = illegal_q;
    end

    // ----------------------------------------------------------- Datapath ---
    always_ff @(posedge clk) begin
        if (restart) begin
            // NOTE: the board is a small flop array, not a RAM, and must read
            // empty right after reset or new_game, so it is reset explicitly.
            board     <= '0;
            cursor    <= CUR_HOME;
            turn_q    <= 1'b1;
            moves     <= '0;
            col_q     <= '0;
            row_q     <= '0;
            dir_q     <= DIR_H;
            winner_q  <= EMPTY;
            illegal_q <= 1'b0;
`ifdef SCORE4_FALL_ANIM_EN
            tick      <= '0;
`endif
        end else begin
            illegal_q <= 1'b0;
            case (state)
                IDLE: begin
                    // drop wins over left/right and uses the current cursor.
                    if (drop) begin
                        if (cur_full) begin
                            illegal_q <= 1'b1;
                        end else begin
                            col_q <= cursor;
                            row_q <= '0;
                            dir_q <= DIR_H;
`ifdef SCORE4_FALL_ANIM_EN
                            tick  <= '0;
`endif
                        end
                    end else if (left && !right) begin
                        cursor <= (cursor == '0) ? CUR_LAST : cursor - 1'b1;
                    end else if (right && !left) begin
                        cursor <= (cursor == CUR_LAST) ? '0 : cursor + 1'b1;
                    end
                end

                FALL: begin
`ifdef SCORE4_FALL_ANIM_EN
                    tick <= (tick == TICK_LAST) ? '0 : tick + 1'b1;
                    if (tick == TICK_LAST && can_step) row_q <= row_q + 1'b1;
`endif
                    if (fall_done) begin
                        board[col_q][land_row] <= disc;
                        row_q                  <= land_row;
                    end
                end

                CHECK: begin
                    if (win_hit) begin
                        winner_q <= disc;
                    end else if (dir_q == DIR_UR) begin
                        moves <= moves + 1'b1;
                        // A full board ends in a draw with no turn change.
                        if (moves != LAST_MOVE) turn_q <= ~turn_q;
                    end else begin
                        dir_q <= dir_t'(dir_q + 2'd1);
                    end
                end

                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_score4_game_engine.sv
// -----------------------------------------------------------------------------
// tb_score4_game_engine
//
// Directed bench for score4_game_engine (7x6, no fall animation). A game
// model held as plain integer arrays tracks board, cursor, turn and result;
// a negedge compare process checks every DUT output against it each cycle,
// and the stimulus adds literal expectations at key points.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_score4_game_engine;

    localparam int COLS = 7;
    localparam int ROWS = 6;

    typedef logic [COLS-1:0][ROWS-1:0][1:0] panel_t;

    logic       clk;
    logic       rst;
    logic       left;
    logic       right;
    logic       drop;
    logic       new_game;
    panel_t     panel;
    logic [COLS-1:0] play;
    logic       turn;
    logic       busy;
    logic       game_over;
    logic [1:0] winner;
    logic       illegal;

    score4_game_engine #(.COLS(COLS), .ROWS(ROWS), .FALL_TICKS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .left      (left),
        .right     (right),
        .drop      (drop),
        .new_game  (new_game),
        .panel     (panel),
        .play      (play),
        .turn      (turn),
        .busy      (busy),
        .game_over (game_over),
        .winner    (winner),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------- Model ---
    // Cells: 0 empty, 1 green, 2 red. m_phase counts cycles since a drop was
    // accepted: disc visible at phase 2, result applied when phase reaches 6.
    int  m_board [COLS][ROWS];
    int  m_cursor;
    bit  m_turn;
    bit  m_over;
    int  m_winner;
    int  m_moves;
    bit  m_illegal;
    int  m_phase;
    int  m_col;
    int  m_row;
    bit  m_will_win;
    bit  m_valid = 1'b0;

    function automatic int colour_of(input bit t);
        return t ? 1 : 2;
    endfunction

    // Brute-force scan of every 4-cell window on the board.
    function automatic bit has_four(input int colour);
        int dcol, drow, cc, rr;
        bit all;
        for (int d = 0; d < 4; d++) begin
            dcol = (d == 1) ? 0 : 1;
            drow = (d == 0) ? 0 : ((d == 3) ? -1 : 1);
            for (int c = 0; c < COLS; c++) begin
                for (int r = 0; r < ROWS; r++) begin
                    all = 1'b1;
                    for (int k = 0; k < 4; k++) begin
                        cc = c + k * dcol;
                        rr = r + k * drow;
                        if (cc < 0 || cc >= COLS || rr < 0 || rr >= ROWS) all = 1'b0;
                        else if (m_board[cc][rr] != colour) all = 1'b0;
                    end
                    if (all) return 1'b1;
                end
            end
        end
        return 1'b0;
    endfunction

    function automatic panel_t exp_panel();
        panel_t p;
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                p[c][r] = 2'(m_board[c][r]);
        return p;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                m_board[c][r] = 0;
        m_cursor   = COLS / 2;
        m_turn     = 1'b1;
        m_over     = 1'b0;
        m_winner   = 0;
        m_moves    = 0;
        m_illegal  = 1'b0;
        m_phase    = 0;
        m_will_win = 1'b0;
    endtask

    task automatic model_step(input bit l, input bit r, input bit d,
                              input bit ng, input bit rl);
        if (rl || ng) begin
            model_reset();
        end else if (m_phase > 0) begin
            m_illegal = 1'b0;
            m_phase++;
            if (m_phase == 2) m_board[m_col][m_row] = colour_of(m_turn);
            if (m_phase == 6) begin
                m_phase = 0;
                if (m_will_win) begin
                    m_over   = 1'b1;
                    m_winner = colour_of(m_turn);
                end else begin
                    m_moves++;
                    if (m_moves == COLS * ROWS) begin
                        m_over   = 1'b1;
                        m_winner = 0;
                    end else begin
                        m_turn = !m_turn;
                    end
                end
            end
        end else if (m_over) begin
            m_illegal = 1'b0;
        end else begin
            m_illegal = 1'b0;
            if (d) begin
                if (m_board[m_cursor][0] != 0) begin
                    m_illegal = 1'b1;
                end else begin
                    m_col = m_cursor;
                    m_row = 0;
                    for (int k = ROWS - 1; k >= 0; k--) begin
                        if (m_board[m_col][k] == 0) begin
                            m_row = k;
                            break;
                        end
                    end
                    m_board[m_col][m_row] = colour_of(m_turn);
                    m_will_win = has_four(colour_of(m_turn));
                    m_board[m_col][m_row] = 0;
                    m_phase = 1;
                end
            end else if (l && !r) begin
                m_cursor = (m_cursor + COLS - 1) % COLS;
            end else if (r && !l) begin
                m_cursor = (m_cursor + 1) % COLS;
            end
        end
    endtask

    // ----------------------------------------------------------- Compare ---
    always @(negedge clk) begin
        if (m_valid) begin
            check("panel",   panel,   exp_panel());
            check("play",    play,    COLS'(1) << m_cursor);
            check("turn",    turn,    m_turn);
            check("illegal", illegal, m_illegal);
            // While a winning drop is still being checked the exact cycle the
            // game ends is not pinned; everything is checked again after it.
            if (!(m_phase > 0 && m_will_win)) begin
                check("busy",      busy,      m_phase > 0);
                check("game_over", game_over, m_over);
                check("winner",    winner,    m_winner);
            end
        end
    end

    // ---------------------------------------------------------- Stimulus ---
    task automatic cycle(input bit l, input bit r, input bit d,
                         input bit ng, input bit rl);
        @(negedge clk);
        left     = l;
        right    = r;
        drop     = d;
        new_game = ng;
        rst      = !rl;
        @(posedge clk);
        model_step(l, r, d, ng, rl);
        m_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
    endtask

    task automatic goto_col(input int col);
        for (int i = 0; i < COLS && m_cursor != col; i++) cycle(0, 1, 0, 0, 0);
    endtask

    task automatic drop_at(input int col);
        goto_col(col);
        cycle(0, 0, 1, 0, 0);
        for (int i = 0; i < 10 && m_phase != 0; i++) idle(1);
    endtask

    initial begin
        rst = 1'b0; left = 1'b0; right = 1'b0; drop = 1'b0; new_game = 1'b0;
        model_reset();

        // Reset state.
        cycle(0, 0, 0, 0, 1);
        #1;
        check("rst_play",  play,      7'b0001000);
        check("rst_turn",  turn,      1'b1);
        check("rst_busy",  busy,      1'b0);
        check("rst_over",  game_over, 1'b0);
        check("rst_panel", panel,     '0);

        // First drop in column 3: latency profile, moves during busy ignored.
        cycle(0, 0, 1, 0, 0);                 // accepted at edge T
        #1 check("t1_busy", busy, 1'b1);
        cycle(1, 0, 1, 0, 0);                 // left+drop while busy
        #1 check("t2_cell", panel[3][5], 2'b01);
        check("t2_play", play, 7'b0001000);
        idle(3);
        #1 check("t5_turn", turn, 1'b1);
        check("t5_busy", busy, 1'b1);
        idle(1);
        #1 check("t6_turn", turn, 1'b0);
        check("t6_busy", busy, 1'b0);

        drop_at(3);
        #1 check("stack_red", panel[3][4], 2'b10);
        check("stack_turn", turn, 1'b1);

        // new_game mid-FALL and rst mid-CHECK abort without a partial write.
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0);
        #1 check("abort_fall_panel", panel, '0);
        check("abort_fall_busy", busy, 1'b0);
        cycle(0, 0, 1, 0, 0);
        idle(2);
        cycle(0, 0, 0, 0, 1);
        #1 check("abort_check_panel", panel, '0);
        check("abort_check_turn", turn, 1'b1);

        // Cursor wrap and simultaneous left/right.
        goto_col(0);
        cycle(1, 0, 0, 0, 0);
        #1 check("wrap_left", play, 7'b1000000);
        cycle(1, 1, 0, 0, 0);
        #1 check("left_right", play, 7'b1000000);
        cycle(0, 1, 0, 0, 0);
        #1 check("wrap_right", play, 7'b0000001);

        // Fill column 0, then a rejected seventh drop.
        for (int i = 0; i < 6; i++) drop_at(0);
        #1 check("col0_top", panel[0][0], 2'b10);
        cycle(0, 0, 1, 0, 0);
        #1 check("illegal_pulse", illegal, 1'b1);
        check("illegal_turn", turn, 1'b1);
        idle(1);
        #1 check("illegal_clear", illegal, 1'b0);

        // Complete a drawn board: cols 0-2,4-6 read G,R,G,R,G,R bottom-up,
        // col 3 reads R,G,R,G,R,G.
        for (int i = 0; i < 6; i++) drop_at(1);
        for (int i = 0; i < 6; i++) drop_at(2);
        drop_at(4);
        for (int i = 0; i < 6; i++) drop_at(3);
        for (int i = 0; i < 5; i++) drop_at(4);
        for (int i = 0; i < 6; i++) drop_at(5);
        for (int i = 0; i < 6; i++) drop_at(6);
        #1 check("draw_over",   game_over, 1'b1);
        check("draw_winner",    winner,    2'b00);
        check("draw_c3_bottom", panel[3][5], 2'b10);
        cycle(0, 0, 1, 0, 0);
        #1 check("draw_no_illegal", illegal, 1'b0);

        cycle(0, 0, 0, 1, 0);
        #1 check("ng_panel", panel, '0);
        check("ng_turn", turn, 1'b1);
        check("ng_over", game_over, 1'b0);

        // Green bottom row 0..3 with red stacking in column 6.
        drop_at(0); drop_at(6);
        drop_at(1); drop_at(6);
        drop_at(2); drop_at(6);
        drop_at(3);
        #1 check("win_over", game_over, 1'b1);
        check("win_winner", winner, 2'b01);
        check("win_busy", busy, 1'b0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        idle(6);
        #1 check("over_play", play, 7'b0001000);
        check("over_frozen", panel[3][4], 2'b00);

        cycle(0, 0, 0, 0, 1);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
